// File: rtl/ddr3_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_arb_pkg
// Shared definitions for the DDR3 Avalon-MM command-port arbiter:
//   - arb_state_e   : grant state (IDLE / RD / WR)
//   - AVL_SIZE_W    : width of the Avalon burst-size field
//   - STREAK_W      : width of the consecutive-read streak counter
//   - STATS_*       : field layout of the 32-bit stats word
//   - burst_beats() : effective write burst length (size 0 means 1 beat)
// ---------------------------------------------------------------------------
package ddr3_arb_pkg;

  localparam int AVL_SIZE_W    = 3;
  localparam int STREAK_W      = 4;   // holds MAX_RD_STREAK up to 15
  localparam int STATS_W       = 32;
  localparam int STATS_FIELD_W = 16;
  localparam int STATS_RD_LSB  = 16;  // stats[31:16] = read grants
  localparam int STATS_WR_LSB  = 0;   // stats[15:0]  = write bursts

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_e;

  // A zero-length write burst still moves one beat.
  function automatic logic [AVL_SIZE_W-1:0] burst_beats(input logic [AVL_SIZE_W-1:0] size);
    return (size == '0) ? AVL_SIZE_W'(1) : size;
  endfunction

endpackage

// File: rtl/ddr3_avl_arbiter_if.sv
// ---------------------------------------------------------------------------
// ddr3_avl_arbiter_if
// Bundles the read-master, write-master and DDR3 controller handshakes that
// meet at the arbiter.
//   slave  : arbiter view (takes requests and avl_ready, drives readies and
//            the Avalon command)
//   master : environment view (read/write masters plus controller)
// Read master : rd_req, rd_size, rd_addr -> rd_ready
// Write master: wr_req, wr_size, wr_addr, wr_data -> wr_ready
// Controller  : avl_ready -> avl_burstbegin, avl_size, avl_read_req,
//               avl_write_req, avl_addr, avl_wr_data
// ---------------------------------------------------------------------------
interface ddr3_avl_arbiter_if
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128
);

  logic                  rd_req;
  logic [AVL_SIZE_W-1:0] rd_size;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_ready;

  logic                  wr_req;
  logic [AVL_SIZE_W-1:0] wr_size;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_ready;

  logic                  avl_ready;
  logic                  avl_burstbegin;
  logic [AVL_SIZE_W-1:0] avl_size;
  logic                  avl_read_req;
  logic                  avl_write_req;
  logic [ADDR_W-1:0]     avl_addr;
  logic [DATA_W-1:0]     avl_wr_data;

  modport slave (
    input  rd_req, rd_size, rd_addr,
    input  wr_req, wr_size, wr_addr, wr_data,
    input  avl_ready,
    output rd_ready, wr_ready,
    output avl_burstbegin, avl_size, avl_read_req, avl_write_req, avl_addr, avl_wr_data
  );

  modport master (
    output rd_req, rd_size, rd_addr,
    output wr_req, wr_size, wr_addr, wr_data,
    output avl_ready,
    input  rd_ready, wr_ready,
    input  avl_burstbegin, avl_size, avl_read_req, avl_write_req, avl_addr, avl_wr_data
  );

endinterface

// File: rtl/ddr3_arb_burst_cnt.sv
// ---------------------------------------------------------------------------
// ddr3_arb_burst_cnt
// Write beat counter for the arbiter's WR grant.
//   ddr3_clk, ddr3_reset_n : clock, asynchronous active-low reset
//   beat_accept            : a write beat is accepted this cycle
//   beats                  : burst length latched at grant (1..7)
//   first                  : no beat of the current burst accepted yet
//   last                   : the next accepted beat completes the burst
// The counter wraps to zero on the final beat, so it is already clear when
// the next write burst is granted.
// ---------------------------------------------------------------------------
module ddr3_arb_burst_cnt
  import ddr3_arb_pkg::*;
(
  input  logic                  ddr3_clk,
  input  logic                  ddr3_reset_n,
  input  logic                  beat_accept,
  input  logic [AVL_SIZE_W-1:0] beats,
  output logic                  first,
  output logic                  last
);

  logic [AVL_SIZE_W-1:0] cnt;

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      cnt <= '0;
    end else if (beat_accept) begin
      cnt <= last ? '0 : cnt + AVL_SIZE_W'(1);
    end
  end

  assign first = (cnt == '0);
  assign last  = (cnt == beats - AVL_SIZE_W'(1));

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_avl_arbiter
// Registered, burst-locked arbiter sharing the single DDR3 Avalon-MM command
// port between the frame read master and the write master (ddr3_clk domain).
//   - Grant is registered (IDLE -> RD/WR); outputs are a combinational mux
//     of the current state, so reset drives every output to 0 at once.
//   - Write bursts are never split; reads are blocked during WR.
//   - A saturating read streak counter forces a write grant after
//     MAX_RD_STREAK consecutive reads taken while a write was waiting.
// Ports:
//   ddr3_clk, ddr3_reset_n : clock, asynchronous active-low reset
//   bus                    : ddr3_avl_arbiter_if.slave (masters + controller)
//   stats                  : {rd_grants[15:0], wr_grants[15:0]}
// Configuration macro: DDR3_ARB_STATS_EN enables the grant counters;
// without it stats is tied to 0.
// ---------------------------------------------------------------------------
module ddr3_avl_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_W        = 26,
  parameter int DATA_W        = 128,
  parameter int MAX_RD_STREAK = 4     // 1..15
) (
  input  logic               ddr3_clk,
  input  logic               ddr3_reset_n,
  ddr3_avl_arbiter_if.slave  bus,
  output logic [STATS_W-1:0] stats
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

  arb_state_e            state;
  arb_state_e            state_nxt;
  logic [STREAK_W-1:0]   streak;
  logic [STREAK_W-1:0]   streak_nxt;
  logic [AVL_SIZE_W-1:0] wr_beats;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_W-1:0]     wr_data_out;

  logic wr_grant;
  logic rd_accept;
  logic wr_accept;
  logic wr_first;
  logic wr_last;
  logic wr_done;

  assign rd_accept = (state == RD) && bus.avl_ready;
  assign wr_accept = (state == WR) && bus.avl_ready && bus.wr_req;
  assign wr_done   = wr_accept && wr_last;

  ddr3_arb_burst_cnt u_burst_cnt (
    .ddr3_clk     (ddr3_clk),
    .ddr3_reset_n (ddr3_reset_n),
    .beat_accept  (wr_accept),
    .beats        (wr_beats),
    .first        (wr_first),
    .last         (wr_last)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      state     <= IDLE;
      streak    <= '0;
      wr_beats  <= '0;
      wr_addr_q <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      // Burst length and address are captured on the grant edge; the write
      // master may move on to its next burst fields once beat 1 is taken.
      if (wr_grant) begin
        wr_beats  <= burst_beats(bus.wr_size);
        wr_addr_q <= bus.wr_addr;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt          = state;
    streak_nxt         = streak;
    wr_grant           = 1'b0;
    bus.rd_ready       = 1'b0;
    bus.wr_ready       = 1'b0;
    bus.avl_burstbegin = 1'b0;
    bus.avl_size       = '0;
    bus.avl_read_req   = 1'b0;
    bus.avl_write_req  = 1'b0;
    bus.avl_addr       = '0;
    wr_data_out        = '0;

    unique case (state)
      IDLE: begin
        // Reads win a tie until the streak limit is reached.
        if (bus.rd_req && (!bus.wr_req || streak != STREAK_MAX)) begin
          state_nxt = RD;
        end else if (bus.wr_req) begin
          state_nxt = WR;
          wr_grant  = 1'b1;
        end
      end

      RD: begin
        bus.avl_read_req   = 1'b1;
        bus.avl_burstbegin = 1'b1;
        bus.avl_size       = bus.rd_size;
        bus.avl_addr       = bus.rd_addr;
        bus.rd_ready       = bus.avl_ready;
        if (rd_accept) begin
          state_nxt = IDLE;
          // Only reads taken while a write waits count toward the limit.
          if (bus.wr_req) begin
            streak_nxt = (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
          end else begin
            streak_nxt = '0;
          end
        end
      end

      WR: begin
        // wr_req low mid-burst is a bubble: no beat, grant held.
        bus.avl_write_req  = bus.wr_req;
        bus.avl_burstbegin = wr_first;
        bus.avl_size       = wr_beats;
        bus.avl_addr       = wr_addr_q;
        wr_data_out        = bus.wr_data;
        bus.wr_ready       = bus.avl_ready && bus.wr_req;
        if (wr_done) begin
          state_nxt  = IDLE;
          streak_nxt = '0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.avl_wr_data = wr_data_out;

`ifdef DDR3_ARB_STATS_EN
  logic [STATS_FIELD_W-1:0] rd_grants;
  logic [STATS_FIELD_W-1:0] wr_grants;

  // Free-running wrapping counters: reads count on acceptance, writes on
  // completion of the final beat.
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      rd_grants <= '0;
      wr_grants <= '0;
    end else begin
      if (rd_accept) rd_grants <= rd_grants + STATS_FIELD_W'(1);
      if (wr_done)   wr_grants <= wr_grants + STATS_FIELD_W'(1);
    end
  end

  always_comb begin
    stats = '0;
    stats[STATS_RD_LSB +: STATS_FIELD_W] = rd_grants;
    stats[STATS_WR_LSB +: STATS_FIELD_W] = wr_grants;
  end
`else
  assign stats = '0;
`endif

endmodule
